spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
- Mode-0 SPI slave engine between the TinyFPGA A2 pads (pin18_cs, pin19_sclk, pin4_mosi, pin20_miso) and the user logic.
- Oversamples the external SPI signals in the sys_clk domain, deserialises MOSI into bytes, and serialises a one-deep transmit holding register onto MISO.
- Presents a strobe/valid-ready interface to downstream register/command logic.

Parameters:
- DATA_WIDTH, 8: bits per SPI word, shifted MSB first.
- SYNC_STAGES, 2: flip-flop synchroniser depth on sclk, cs_n and mosi; minimum 2.

Ports:
- sys_clk  in  1  system clock; must be at least 4x the SPI sclk frequency.
- sys_rst  in  1  reset; synchronous, active-high.
- spi_sclk  in  1  raw SPI clock from pad; CPOL=0.
- spi_cs_n  in  1  raw chip select from pad; active low.
- spi_mosi  in  1  raw master-out data from pad.
- spi_miso  out  1  slave-out data to the pad.
- spi_miso_oe  out  1  MISO output enable; drives the pad tristate.
- rx_data  out  DATA_WIDTH  last complete received word.
- rx_valid  out  1  single-cycle strobe; rx_data is new in this cycle.
- tx_data  in  DATA_WIDTH  next word to transmit.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  holding register empty.
- tx_underrun  out  1  single-cycle pulse; a word boundary found no pending tx word.
- busy  out  1  synchronised CS is active.

Behaviour:
- Reset (sys_rst=1 at a sys_clk edge) forces:
  - spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, busy=0.
  - Synchroniser chains are preset to idle: sclk=0, cs_n=1, mosi=0.
  - Bit counter, shift registers, pending flag and load_next flag are cleared.
  - Reset mid-transfer discards the partial word and any pending tx word. After reset the core waits for the next CS falling edge; an already-low CS is not treated as a new assertion.
- Edge detection: sclk_s and cs_s are the synchroniser outputs, each with a one-cycle delayed copy. rise = sclk_s & ~sclk_d; fall = ~sclk_s & sclk_d; cs_start = ~cs_s & cs_d; cs_end = cs_s & ~cs_d.
- States:
  - IDLE: busy=0, spi_miso_oe=0, edges on sclk are ignored. On cs_start go to ACTIVE:
    - bit_cnt=0;
    - shift_tx loads the pending word if present (pending cleared), else 0 with a tx_underrun pulse;
    - spi_miso_oe=1.
  - ACTIVE:
    - On rise: shift_rx <= {shift_rx[W-2:0], mosi_s}; bit_cnt increments.
    - When bit_cnt reaches DATA_WIDTH, all of the following happen in the same cycle:
      - rx_data <= the completed word;
      - rx_valid pulses for 1 cycle;
      - bit_cnt wraps to 0;
      - load_next is set.
    - On fall: if load_next, shift_tx loads the pending word (or 0 with a tx_underrun pulse) and load_next clears; otherwise shift_tx shifts left by 1.
    - On cs_end: return to IDLE immediately. Partial bits are discarded, no rx_valid, load_next is cleared, the pending tx word is retained.
- spi_miso = shift_tx[DATA_WIDTH-1] registered; it is held at 0 whenever spi_miso_oe=0.
- Latency: rx_valid is asserted exactly SYNC_STAGES+2 sys_clk cycles after the raw sclk rising edge that carries the last bit.
- TX handshake:
  - tx_ready = ~pending.
  - A transfer happens when tx_valid & tx_ready at a clock edge; tx_data is captured and pending is set.
  - If a load and a capture occur in the same cycle, the load takes the old pending word; a new capture is impossible in that cycle because tx_ready=0 when pending=1.
  - tx_valid while tx_ready=0 is ignored, and the upstream logic must hold it.
- busy mirrors the state (1 in ACTIVE).
- rx has no backpressure: the consumer must accept rx_valid unconditionally.

Test Plan:
- Single word: preload tx 0x3C, assert CS, master clocks 0xA5 at sys_clk/8 → rx_data=0xA5 with exactly one rx_valid pulse; master samples 0x3C on MISO; tx_ready returns to 1 at CS start; no underrun.
- Back-to-back: preload 0x11, then offer 0x22 once tx_ready=1; master sends 0xF0, 0x0F in one CS window → rx_valid pulses twice with 0xF0 then 0x0F; MISO carries 0x11 then 0x22; no underrun.
- Underrun: no tx word pending, CS asserted, one word clocked → MISO all zero; tx_underrun pulses exactly once, at CS start.
- CS abort: 3 bits clocked, then CS deasserted; a full 0x5A word follows in a new CS window → no rx_valid for the fragment; rx_data=0x5A afterwards.
- Reset mid-word: assert sys_rst after bit 4 with 0x77 pending → all outputs at reset values, tx_ready=1, busy=0; a later full transaction with no new tx word gives an underrun and MISO zeros.
- Latency/idle: measure raw last sclk rise to rx_valid → SYNC_STAGES+2 = 4 cycles; toggling sclk with CS high → no rx_valid, spi_miso_oe=0.

Source files
------------

// File: rtl/spi_slave_core.sv
// spi_slave_core: mode-0 (CPOL=0, CPHA=0) SPI slave engine.
// Oversamples the pad-level SPI signals in the sys_clk domain. MOSI is shifted
// into words MSB first, and a one-deep transmit holding register is serialised
// onto MISO.
//
// Ports:
//   sys_clk, sys_rst        system clock and synchronous active-high reset
//   spi_sclk/cs_n/mosi      raw pad inputs (asynchronous to sys_clk)
//   spi_miso, spi_miso_oe   registered slave-out data and its pad output enable
//   rx_data, rx_valid       last received word and its one-cycle strobe
//   tx_data/valid/ready     valid-ready handshake into the tx holding register
//   tx_underrun             one-cycle pulse when a word boundary found nothing pending
//   busy                    synchronised chip select is active
module spi_slave_core #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int unsigned CntW   = $clog2(DATA_WIDTH + 1);
  localparam int unsigned FlushW = $clog2(SYNC_STAGES + 2);
  localparam logic [CntW-1:0]   CntMax    = CntW'(DATA_WIDTH);
  localparam logic [FlushW-1:0] FlushInit = FlushW'(SYNC_STAGES + 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e                state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                  sclk_d_q, cs_d_q;
  logic [FlushW-1:0]     flush_q;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_rx_q, shift_rx_d;
  logic [DATA_WIDTH-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  pending_q, pending_d;
  logic                  load_next_q, load_next_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  miso_q, miso_d;
  logic                  load;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_start, cs_end;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d_q;
  assign sclk_fall = ~sclk_s & sclk_d_q;
  // The chains are preset to idle on reset, so a CS already held low would
  // otherwise look like a fresh assertion while they flush; mask it.
  assign cs_start  = ~cs_s & cs_d_q & (flush_q == '0);
  assign cs_end    = cs_s & ~cs_d_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_rx_d  = shift_rx_q;
    shift_tx_d  = shift_tx_q;
    hold_d      = hold_q;
    rx_data_d   = rx_data_q;
    pending_d   = pending_q;
    load_next_d = load_next_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;

    case (state_q)
      StIdle: begin
        if (cs_start) begin
          state_d   = StActive;
          bit_cnt_d = '0;
          load      = 1'b1;
        end
      end
      StActive: begin
        if (cs_end) begin
          state_d     = StIdle;
          bit_cnt_d   = '0;
          shift_rx_d  = '0;
          load_next_d = 1'b0;
        end else begin
          if (bit_cnt_q == CntMax) begin
            rx_data_d   = shift_rx_q;
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            load_next_d = 1'b1;
          end
          if (sclk_rise) begin
            shift_rx_d = {shift_rx_q[DATA_WIDTH-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_d + 1'b1;
          end
          if (sclk_fall) begin
            if (load_next_q) begin
              load        = 1'b1;
              load_next_d = 1'b0;
            end else begin
              shift_tx_d = shift_tx_q << 1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A load always consumes the old pending word; capture needs pending=0,
    // so both in one cycle only happens on an underrun load.
    if (load) begin
      if (pending_q) begin
        shift_tx_d = hold_q;
        pending_d  = 1'b0;
      end else begin
        shift_tx_d = '0;
        underrun_d = 1'b1;
      end
    end
    if (tx_valid && !pending_q) begin
      hold_d    = tx_data;
      pending_d = 1'b1;
    end

    // Registered from the next-state values so MISO changes in the same cycle
    // as the shift register, leaving the master the most setup time.
    miso_d = (state_d == StActive) ? shift_tx_d[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_d_q    <= 1'b0;
      cs_d_q      <= 1'b1;
      flush_q     <= FlushInit;
      bit_cnt_q   <= '0;
      shift_rx_q  <= '0;
      shift_tx_q  <= '0;
      hold_q      <= '0;
      rx_data_q   <= '0;
      pending_q   <= 1'b0;
      load_next_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_d_q    <= sclk_s;
      cs_d_q      <= cs_s;
      if (flush_q != '0) flush_q <= flush_q - 1'b1;
      bit_cnt_q   <= bit_cnt_d;
      shift_rx_q  <= shift_rx_d;
      shift_tx_q  <= shift_tx_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      pending_q   <= pending_d;
      load_next_q <= load_next_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      miso_q      <= miso_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q == StActive);
  assign busy        = (state_q == StActive);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = ~pending_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a bit-banged mode-0 master running at
// sys_clk/8, plus a monitor that logs rx words, underrun pulses and latency.
module tb_spi_slave_core;

  localparam int unsigned Hp = 4;  // sclk half period in sys_clk cycles

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_underrun, busy;

  spi_slave_core #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Monitor state, sampled on the falling edge away from DUT updates.
  int unsigned rx_cnt = 0;
  int unsigned underrun_cnt = 0;
  logic [7:0]  rx_log [0:63];
  time         t_last_rise = 0;
  int unsigned last_lat = 0;
  logic        oe_seen = 1'b0;

  always @(negedge sys_clk) begin
    if (rx_valid) begin
      if (rx_cnt < 64) rx_log[rx_cnt] = rx_data;
      rx_cnt   = rx_cnt + 1;
      last_lat = int'(($time - t_last_rise) / 10);
    end
    if (tx_underrun) underrun_cnt = underrun_cnt + 1;
    if (spi_miso_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic offer_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    cycles(1);
    tx_valid = 1'b0;
    cycles(1);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    cycles(8);
  endtask

  // Raise CS while sclk is still high so the trailing fall lands in idle.
  task automatic cs_high();
    spi_cs_n = 1'b1;
    cycles(Hp);
    spi_sclk = 1'b0;
    cycles(8);
  endtask

  // Clock nbits of b MSB first; MISO is sampled just before each rising edge.
  task automatic xfer(input logic [7:0] b, input int unsigned nbits, output logic [7:0] miso_b);
    miso_b = '0;
    for (int i = 7; i > 7 - int'(nbits); i--) begin
      spi_sclk = 1'b0;
      spi_mosi = b[i];
      cycles(Hp);
      miso_b[i] = spi_miso;
      spi_sclk = 1'b1;
      t_last_rise = $time;
      cycles(Hp);
    end
  endtask

  logic [7:0]  mb;
  int unsigned rx0, ur0;

  initial begin
    sys_rst  = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    cycles(3);
    sys_rst = 1'b0;
    cycles(4);

    check("rst_miso", spi_miso, 0);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_underrun", tx_underrun, 0);
    check("rst_busy", busy, 0);

    // Single word: MOSI 0xA5, MISO 0x3C.
    rx0 = rx_cnt; ur0 = underrun_cnt;
    offer_tx(8'h3C);
    check("single_ready_low", tx_ready, 0);
    cs_low();
    check("single_ready_back", tx_ready, 1);
    check("single_busy", busy, 1);
    check("single_oe", spi_miso_oe, 1);
    xfer(8'hA5, 8, mb);
    cs_high();
    check("single_miso", mb, 8'h3C);
    check("single_rx_cnt", rx_cnt - rx0, 1);
    check("single_rx_data", rx_data, 8'hA5);
    check("single_underrun", underrun_cnt - ur0, 0);
    check("latency", last_lat, 4);
    check("single_busy_end", busy, 0);

    // Back-to-back words in one CS window.
    rx0 = rx_cnt; ur0 = underrun_cnt;
    offer_tx(8'h11);
    cs_low();
    check("b2b_ready", tx_ready, 1);
    offer_tx(8'h22);
    xfer(8'hF0, 8, mb);
    check("b2b_miso0", mb, 8'h11);
    xfer(8'h0F, 8, mb);
    check("b2b_miso1", mb, 8'h22);
    cs_high();
    check("b2b_rx_cnt", rx_cnt - rx0, 2);
    check("b2b_rx0", rx_log[rx0], 8'hF0);
    check("b2b_rx1", rx_log[rx0+1], 8'h0F);
    check("b2b_underrun", underrun_cnt - ur0, 0);

    // Underrun: nothing pending at CS start.
    rx0 = rx_cnt; ur0 = underrun_cnt;
    cs_low();
    check("ur_at_start", underrun_cnt - ur0, 1);
    xfer(8'hC3, 8, mb);
    cs_high();
    check("ur_miso", mb, 8'h00);
    check("ur_total", underrun_cnt - ur0, 1);
    check("ur_rx_data", rx_data, 8'hC3);

    // CS abort after 3 bits, then a full word.
    rx0 = rx_cnt;
    cs_low();
    xfer(8'hE7, 3, mb);
    cs_high();
    check("abort_no_rx", rx_cnt - rx0, 0);
    cs_low();
    xfer(8'h5A, 8, mb);
    cs_high();
    check("abort_rx_cnt", rx_cnt - rx0, 1);
    check("abort_rx_data", rx_data, 8'h5A);

    // Reset mid-word with 0x77 pending behind 0x33.
    offer_tx(8'h33);
    cs_low();
    offer_tx(8'h77);
    check("rstmid_pending", tx_ready, 0);
    xfer(8'h99, 4, mb);
    sys_rst = 1'b1;
    cycles(2);
    check("rstmid_miso", spi_miso, 0);
    check("rstmid_oe", spi_miso_oe, 0);
    check("rstmid_rx_data", rx_data, 0);
    check("rstmid_rx_valid", rx_valid, 0);
    check("rstmid_tx_ready", tx_ready, 1);
    check("rstmid_underrun", tx_underrun, 0);
    check("rstmid_busy", busy, 0);
    sys_rst = 1'b0;
    cycles(10);
    check("rstmid_cs_held", busy, 0);
    cs_high();
    rx0 = rx_cnt; ur0 = underrun_cnt;
    cs_low();
    xfer(8'h3B, 8, mb);
    cs_high();
    check("rstmid_miso_zero", mb, 8'h00);
    check("rstmid_ur", underrun_cnt - ur0, 1);
    check("rstmid_rx", rx_data, 8'h3B);

    // sclk activity with CS high must be ignored.
    rx0 = rx_cnt;
    oe_seen = 1'b0;
    xfer(8'hFF, 8, mb);
    spi_sclk = 1'b0;
    cycles(8);
    check("idle_no_rx", rx_cnt - rx0, 0);
    check("idle_oe", oe_seen, 0);
    check("idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
